// File: rtl/ram_arbiter_if.sv
// Requester and RAM-side bundle for the work-RAM arbiter.
// The slave side is the arbiter; the master side holds the requesters and the RAM.
interface ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic [ADDR_W-1:0] ram_address;
    logic              ram_write_en;
    logic [DATA_W-1:0] ram_write_data;
    logic [DATA_W-1:0] ram_read_data;
    logic              ram_noe;

    logic              busy;
    logic              grant;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_read_data,
        output a_ack, a_rdata, b_ack, b_rdata,
        output ram_address, ram_write_en, ram_write_data, ram_noe, busy, grant
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, ram_read_data,
        input  a_ack, a_rdata, b_ack, b_rdata,
        input  ram_address, ram_write_en, ram_write_data, ram_noe, busy, grant
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port round-robin sequencer for the asynchronous 256x8 work RAM.
// Each transfer runs SETUP -> STROBE (ACCESS_CYCLES) -> HOLD with address/data framing the strobe.
module ram_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    ram_arbiter_if.slave   bus
);
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              last_b;
    logic              grant_q;
    logic              we_q;
    logic              pick_b;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    // On a tie the port that did not win last time gets the RAM.
    assign pick_b = bus.b_req && (!bus.a_req || !last_b);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.a_req || bus.b_req) state_nxt = SETUP;
            SETUP:   state_nxt = STROBE;
            STROBE:  if (cnt == '0) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            last_b    <= 1'b1;
            grant_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.a_req || bus.b_req) begin
                    grant_q <= pick_b;
                    last_b  <= pick_b;
                    we_q    <= pick_b ? bus.b_we    : bus.a_we;
                    addr_q  <= pick_b ? bus.b_addr  : bus.a_addr;
                    wdata_q <= pick_b ? bus.b_wdata : bus.a_wdata;
                end
                SETUP: cnt <= CNT_W'(ACCESS_CYCLES - 1);
                STROBE: begin
                    if (cnt != '0) cnt <= cnt - CNT_W'(1);
                    // Capture on entry to HOLD so read data is valid alongside the ack.
                    else if (!we_q) begin
                        if (grant_q) b_rdata_q <= bus.ram_read_data;
                        else         a_rdata_q <= bus.ram_read_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.ram_write_en = 1'b0;
        bus.ram_noe      = 1'b1;
        bus.a_ack        = 1'b0;
        bus.b_ack        = 1'b0;
        bus.busy         = (state != IDLE);
        case (state)
            SETUP:  bus.ram_noe = we_q;
            STROBE: begin
                bus.ram_noe      = we_q;
                bus.ram_write_en = we_q;
            end
            HOLD: begin
                bus.ram_noe = we_q;
                bus.a_ack   = !grant_q;
                bus.b_ack   = grant_q;
            end
            default: ;
        endcase
    end

    assign bus.ram_address    = addr_q;
    assign bus.ram_write_data = wdata_q;
    assign bus.a_rdata        = a_rdata_q;
    assign bus.b_rdata        = b_rdata_q;
    assign bus.grant          = grant_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench: two arbiters (ACCESS_CYCLES 1 and 3), each with a behavioural RAM,
// driven by directed and random rounds and checked against a transfer-level model.
module tb_ram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_v     [2];
    logic       a_req_v   [2];
    logic       a_we_v    [2];
    logic [7:0] a_addr_v  [2];
    logic [7:0] a_wdata_v [2];
    logic       b_req_v   [2];
    logic       b_we_v    [2];
    logic [7:0] b_addr_v  [2];
    logic [7:0] b_wdata_v [2];
    logic       a_ack_v   [2];
    logic [7:0] a_rdata_v [2];
    logic       b_ack_v   [2];
    logic [7:0] b_rdata_v [2];
    logic [7:0] addr_v    [2];
    logic [7:0] wdata_v   [2];
    logic       we_v      [2];
    logic       noe_v     [2];
    logic       busy_v    [2];
    logic       grant_v   [2];

    for (genvar g = 0; g < 2; g++) begin : gd
        logic [7:0] mem [256] = '{default: 8'h00};
        ram_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();
        ram_arbiter #(.ADDR_W(8), .DATA_W(8), .ACCESS_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk),
            .rst(rst_v[g]),
            .bus(bus)
        );
        assign bus.a_req         = a_req_v[g];
        assign bus.a_we          = a_we_v[g];
        assign bus.a_addr        = a_addr_v[g];
        assign bus.a_wdata       = a_wdata_v[g];
        assign bus.b_req         = b_req_v[g];
        assign bus.b_we          = b_we_v[g];
        assign bus.b_addr        = b_addr_v[g];
        assign bus.b_wdata       = b_wdata_v[g];
        assign bus.ram_read_data = bus.ram_noe ? 8'h00 : mem[bus.ram_address];
        assign a_ack_v[g]   = bus.a_ack;
        assign a_rdata_v[g] = bus.a_rdata;
        assign b_ack_v[g]   = bus.b_ack;
        assign b_rdata_v[g] = bus.b_rdata;
        assign addr_v[g]    = bus.ram_address;
        assign wdata_v[g]   = bus.ram_write_data;
        assign we_v[g]      = bus.ram_write_en;
        assign noe_v[g]     = bus.ram_noe;
        assign busy_v[g]    = bus.busy;
        assign grant_v[g]   = bus.grant;
        always @(posedge clk) if (bus.ram_write_en) mem[bus.ram_address] <= bus.ram_write_data;
    end

    typedef struct {
        logic       port;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] ard;
        logic [7:0] brd;
    } exp_t;

    exp_t       sb [2][$];
    logic [7:0] ref_mem [2][256];
    logic       last_b  [2];
    logic [7:0] ref_ard [2];
    logic [7:0] ref_brd [2];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       mon_en   = 1'b0;

    function automatic int ac_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h at %0t", name, d, act, expv, $time);
        end
    endtask

    // Transfer-level model: applies one completed transfer to the reference RAM and rdata registers.
    task automatic push(input int d, input logic p, input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        exp_t e;
        if (we)     ref_mem[d][addr] = wdata;
        else if (p) ref_brd[d] = ref_mem[d][addr];
        else        ref_ard[d] = ref_mem[d][addr];
        last_b[d] = p;
        e.port = p; e.we = we; e.addr = addr; e.wdata = wdata;
        e.ard = ref_ard[d]; e.brd = ref_brd[d];
        sb[d].push_back(e);
    endtask

    task automatic model_reset(input int d);
        last_b[d] = 1'b1;
        ref_ard[d] = 8'h00;
        ref_brd[d] = 8'h00;
    endtask

    task automatic run_round(input int d, input logic ua, input logic wa, input logic [7:0] aa, input logic [7:0] da,
                             input logic ub, input logic wb, input logic [7:0] ab, input logic [7:0] db,
                             input logic ea, input logic eb);
        logic pa, pb;
        int   cyc;
        if (ua && ub) begin
            if (last_b[d]) begin push(d, 1'b0, wa, aa, da); push(d, 1'b1, wb, ab, db); end
            else           begin push(d, 1'b1, wb, ab, db); push(d, 1'b0, wa, aa, da); end
        end else if (ua) push(d, 1'b0, wa, aa, da);
        else if (ub)     push(d, 1'b1, wb, ab, db);
        @(negedge clk);
        a_we_v[d] = wa; a_addr_v[d] = aa; a_wdata_v[d] = da; a_req_v[d] = ua;
        b_we_v[d] = wb; b_addr_v[d] = ab; b_wdata_v[d] = db; b_req_v[d] = ub;
        pa = ua; pb = ub; cyc = 0;
        while ((pa || pb) && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (pa && a_ack_v[d]) begin a_req_v[d] = 1'b0; pa = 1'b0; end
            else if (pa && ea && busy_v[d] && grant_v[d] == 1'b0) a_req_v[d] = 1'b0;
            if (pb && b_ack_v[d]) begin b_req_v[d] = 1'b0; pb = 1'b0; end
            else if (pb && eb && busy_v[d] && grant_v[d] == 1'b1) b_req_v[d] = 1'b0;
        end
        chk("round_timeout", d, {31'd0, cyc < 60}, 32'd1);
        a_req_v[d] = 1'b0; b_req_v[d] = 1'b0;
    endtask

    task automatic pulse_rst_check(input int d);
        rst_v[d] = 1'b1;
        @(negedge clk);
        chk("rst_we", d, {31'd0, we_v[d]}, 32'd0);
        chk("rst_noe", d, {31'd0, noe_v[d]}, 32'd1);
        chk("rst_busy", d, {31'd0, busy_v[d]}, 32'd0);
        chk("rst_ack", d, {30'd0, a_ack_v[d], b_ack_v[d]}, 32'd0);
        chk("rst_ardata", d, {24'd0, a_rdata_v[d]}, 32'd0);
        rst_v[d] = 1'b0;
        model_reset(d);
    endtask

    // Monitor: per-cycle protocol rules plus per-transfer framing, compared at each ack.
    int         busy_n [2], we_n [2], noe_n [2], we_first [2], moved [2];
    logic [7:0] addr0  [2], wd0  [2];
    initial begin
        for (int d = 0; d < 2; d++) begin
            busy_n[d] = 0; we_n[d] = 0; noe_n[d] = 0; we_first[d] = 0; moved[d] = 0;
        end
        forever begin
            @(negedge clk);
            if (mon_en) begin
                for (int d = 0; d < 2; d++) begin
                    if (!busy_v[d]) begin
                        chk("idle_we", d, {31'd0, we_v[d]}, 32'd0);
                        chk("idle_noe", d, {31'd0, noe_v[d]}, 32'd1);
                    end
                    chk("dual_ack", d, {31'd0, a_ack_v[d] && b_ack_v[d]}, 32'd0);
                    if (busy_v[d]) begin
                        busy_n[d]++;
                        if (busy_n[d] == 1) begin addr0[d] = addr_v[d]; wd0[d] = wdata_v[d]; end
                        else if (addr_v[d] !== addr0[d] || wdata_v[d] !== wd0[d]) moved[d] = 1;
                        if (we_v[d]) begin
                            we_n[d]++;
                            if (we_first[d] == 0) we_first[d] = busy_n[d];
                        end
                        if (!noe_v[d]) noe_n[d]++;
                    end
                    if (a_ack_v[d] || b_ack_v[d]) begin
                        if (sb[d].size() == 0) chk("unexpected_ack", d, 32'd1, 32'd0);
                        else begin
                            exp_t e;
                            e = sb[d].pop_front();
                            chk("ack_port", d, {31'd0, b_ack_v[d]}, {31'd0, e.port});
                            chk("grant", d, {31'd0, grant_v[d]}, {31'd0, e.port});
                            chk("latency", d, busy_n[d], 2 + ac_of(d));
                            chk("we_cycles", d, we_n[d], e.we ? ac_of(d) : 0);
                            chk("we_first", d, we_first[d], e.we ? 2 : 0);
                            chk("noe_cycles", d, noe_n[d], e.we ? 0 : 2 + ac_of(d));
                            chk("addr", d, {24'd0, addr0[d]}, {24'd0, e.addr});
                            chk("addr_data_stable", d, moved[d], 0);
                            if (e.we) chk("wdata", d, {24'd0, wd0[d]}, {24'd0, e.wdata});
                            chk("a_rdata", d, {24'd0, a_rdata_v[d]}, {24'd0, e.ard});
                            chk("b_rdata", d, {24'd0, b_rdata_v[d]}, {24'd0, e.brd});
                        end
                    end
                    if (!busy_v[d]) begin
                        busy_n[d] = 0; we_n[d] = 0; noe_n[d] = 0; we_first[d] = 0; moved[d] = 0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        for (int d = 0; d < 2; d++) begin
            rst_v[d] = 1'b1;
            a_req_v[d] = 1'b0; a_we_v[d] = 1'b0; a_addr_v[d] = 8'h00; a_wdata_v[d] = 8'h00;
            b_req_v[d] = 1'b0; b_we_v[d] = 1'b0; b_addr_v[d] = 8'h00; b_wdata_v[d] = 8'h00;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'h00;
            model_reset(d);
        end
        repeat (3) @(negedge clk);
        rst_v[0] = 1'b0; rst_v[1] = 1'b0;
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("idle5_we", d, {31'd0, we_v[d]}, 32'd0);
            chk("idle5_noe", d, {31'd0, noe_v[d]}, 32'd1);
            chk("idle5_busy", d, {31'd0, busy_v[d]}, 32'd0);
            chk("idle5_acks", d, {30'd0, a_ack_v[d], b_ack_v[d]}, 32'd0);
            chk("idle5_ardata", d, {24'd0, a_rdata_v[d]}, 32'd0);
            chk("idle5_brdata", d, {24'd0, b_rdata_v[d]}, 32'd0);
            chk("idle5_grant", d, {31'd0, grant_v[d]}, 32'd0);
        end

        // Simultaneous requests alternate A,B from reset.
        for (int k = 0; k < 4; k++)
            run_round(0, 1'b1, k[0], 8'h20 + 8'(k), 8'hA0 + 8'(k), 1'b1, ~k[0], 8'h30 + 8'(k), 8'hB0 + 8'(k), 1'b0, 1'b0);

        run_round(0, 1'b1, 1'b1, 8'h10, 8'h42, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        run_round(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);

        // Reset while the write strobe is high: transfer discarded, no ack.
        @(negedge clk);
        a_we_v[0] = 1'b1; a_addr_v[0] = 8'h77; a_wdata_v[0] = 8'h5A; a_req_v[0] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!we_v[0] && cyc < 20);
        chk("strobe_seen", 0, {31'd0, we_v[0]}, 32'd1);
        a_req_v[0] = 1'b0;
        ref_mem[0][8'h77] = 8'h5A;
        pulse_rst_check(0);

        // Reset before the strobe: the RAM word must keep its old value.
        a_we_v[0] = 1'b1; a_addr_v[0] = 8'h78; a_wdata_v[0] = 8'hA5; a_req_v[0] = 1'b1;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!busy_v[0] && cyc < 20);
        chk("setup_seen", 0, {31'd0, busy_v[0] && !we_v[0]}, 32'd1);
        a_req_v[0] = 1'b0;
        pulse_rst_check(0);
        run_round(0, 1'b1, 1'b0, 8'h77, 8'h00, 1'b1, 1'b0, 8'h78, 8'h00, 1'b0, 1'b0);

        run_round(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_round(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0);
        run_round(1, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1, 8'h00, 8'h3C, 1'b1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            int         d, mode;
            logic [7:0] aa, ab;
            d = n % 2;
            mode = $urandom_range(0, 2);
            aa = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            ab = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
            run_round(d, mode != 1, 1'($urandom), aa, 8'($urandom),
                         mode != 0, 1'($urandom), ab, 8'($urandom),
                         $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end

        repeat (4) @(negedge clk);
        chk("sb_empty", 0, sb[0].size(), 0);
        chk("sb_empty", 1, sb[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
